// File: rtl/v_pipe_query_replay.sv
// v_pipe_query_replay: list-state query pipeline that parks update-collided
// queries in a small replay queue and reissues them after a fixed wait.

package v_pkg;
    localparam int unsigned ID_W    = 8;
    localparam int unsigned LEVELS  = 4;
    localparam int unsigned LEVEL_W = 2;
    localparam int unsigned KEY_W   = 16;
    localparam int unsigned VOL_W   = 16;
    localparam int unsigned LS_W    = 3;

    typedef logic [ID_W-1:0]    id_t;
    typedef logic [ID_W-1:0]    addr_t;
    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [KEY_W-1:0]   key_t;
    typedef logic [VOL_W-1:0]   volume_t;
    typedef logic [LS_W-1:0]    listsize_t;

    typedef struct packed {
        logic [LEVELS-1:0]    vld;
        listsize_t            listsize;
        key_t    [LEVELS-1:0] key;
        volume_t [LEVELS-1:0] volume;
    } state_t;
endpackage

module v_pipe_query_replay #(
    parameter int unsigned UPD_STAGES_N = 4,
    parameter int unsigned REPLAY_N     = 2,
    parameter int unsigned RETRY_MAX    = 3,
    parameter int unsigned REPLAY_WAIT  = 4,
    parameter int unsigned OUT_REG      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_lut_vld,
    input  v_pkg::id_t                    i_lut_prod_id,
    input  v_pkg::level_t                 i_lut_level,
    input  logic [7:0]                    i_lut_tag,
    output logic                          o_lut_ready,
    output logic                          o_lut_vld_r,
    output logic [7:0]                    o_lut_tag,
    output v_pkg::key_t                   o_lut_key,
    output v_pkg::volume_t                o_lut_size,
    output v_pkg::listsize_t              o_lut_listsize,
    output logic                          o_lut_error,
    output logic [1:0]                    o_lut_err_code,
    output logic                          o_state_ren,
    output v_pkg::addr_t                  o_state_raddr,
    input  v_pkg::state_t                 i_state_rdata,
    input  logic [UPD_STAGES_N-1:0]       i_upd_vld_r,
    input  v_pkg::id_t [UPD_STAGES_N-1:0] i_upd_prod_id_r
);
    localparam int unsigned OCC_W  = $clog2(REPLAY_N + 1);
    localparam int unsigned PTR_W  = (REPLAY_N > 1) ? $clog2(REPLAY_N) : 1;
    localparam int unsigned RTY_W  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int unsigned WAIT_W = $clog2(REPLAY_WAIT + 1);
    localparam int unsigned LVL_N  = v_pkg::LEVELS;

    typedef struct packed {
        v_pkg::id_t       id;
        v_pkg::level_t    level;
        logic [7:0]       tag;
        logic [RTY_W-1:0] retry;
    } rp_entry_t;

    rp_entry_t         rp_q [REPLAY_N];
    logic [PTR_W-1:0]  head_r, tail_r;
    logic [OCC_W-1:0]  occ_r;
    logic [WAIT_W-1:0] wait_r;

    logic              s1_vld_r;
    v_pkg::id_t        s1_id_r;
    v_pkg::level_t     s1_level_r;
    logic [LVL_N-1:0]  s1_oh_r;
    logic [7:0]        s1_tag_r;
    logic              s1_busy_r;
    logic [RTY_W-1:0]  s1_retry_r;

    rp_entry_t         head_c;
    logic              replay_issue_c, room_c, issue_c, busy_s0_c;
    v_pkg::id_t        s0_id_c;
    v_pkg::level_t     s0_level_c;
    logic [7:0]        s0_tag_c;
    logic [RTY_W-1:0]  s0_retry_c;

    logic              busy_c, invalid_c, push_c, resp_c, err_c;
    logic [1:0]        code_c;
    v_pkg::key_t       key_c;
    v_pkg::volume_t    vol_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REPLAY_N - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // S0: pick replay head or new input, drive the state read, check collisions
    always_comb begin
        head_c         = rp_q[head_r];
        replay_issue_c = (occ_r != '0) && (wait_r == WAIT_W'(REPLAY_WAIT));
        room_c         = (RETRY_MAX == 0) ||
                         (((OCC_W+1)'(occ_r) + (OCC_W+1)'(s1_vld_r)) < (OCC_W+1)'(REPLAY_N));
        o_lut_ready    = !replay_issue_c && room_c;
        issue_c        = replay_issue_c || (i_lut_vld && o_lut_ready);
        s0_id_c        = replay_issue_c ? head_c.id    : i_lut_prod_id;
        s0_level_c     = replay_issue_c ? head_c.level : i_lut_level;
        s0_tag_c       = replay_issue_c ? head_c.tag   : i_lut_tag;
        s0_retry_c     = replay_issue_c ? head_c.retry : '0;
        o_state_ren    = issue_c;
        o_state_raddr  = s0_id_c;
        busy_s0_c      = 1'b0;
        for (int k = 0; k < UPD_STAGES_N; k++) begin
            if (i_upd_vld_r[k] && (i_upd_prod_id_r[k] == s0_id_c)) busy_s0_c = 1'b1;
        end
    end

    // S1 valid
    always_ff @(posedge clk) begin
        if (rst) s1_vld_r <= 1'b0;
        else     s1_vld_r <= issue_c;
    end

    // S1 payload, loaded on every issue
    always_ff @(posedge clk) begin
        if (issue_c) begin
            s1_id_r    <= s0_id_c;
            s1_level_r <= s0_level_c;
            s1_oh_r    <= LVL_N'(1) << s0_level_c;
            s1_tag_r   <= s0_tag_c;
            s1_busy_r  <= busy_s0_c;
            s1_retry_r <= s0_retry_c;
        end
    end

    // S1: late collision check, level mux, and replay/respond decision
    always_comb begin
        busy_c    = s1_busy_r || (i_upd_vld_r[0] && (i_upd_prod_id_r[0] == s1_id_r));
        invalid_c = (s1_oh_r & i_state_rdata.vld) == '0;
        key_c     = '0;
        vol_c     = '0;
        for (int l = 0; l < LVL_N; l++) begin
            if (s1_oh_r[l]) begin
                key_c = key_c | i_state_rdata.key[l];
                vol_c = vol_c | i_state_rdata.volume[l];
            end
        end
        push_c = s1_vld_r && busy_c && (s1_retry_r != RTY_W'(RETRY_MAX));
        resp_c = s1_vld_r && !push_c;
        err_c  = busy_c || invalid_c;
        code_c = busy_c ? 2'd2 : (invalid_c ? 2'd1 : 2'd0);
    end

    // Replay queue pointers, occupancy and head wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= '0;
            tail_r <= '0;
            occ_r  <= '0;
            wait_r <= '0;
        end else begin
            if (push_c)         tail_r <= ptr_inc(tail_r);
            if (replay_issue_c) head_r <= ptr_inc(head_r);
            if (push_c && !replay_issue_c)      occ_r <= occ_r + OCC_W'(1);
            else if (!push_c && replay_issue_c) occ_r <= occ_r - OCC_W'(1);
            if (replay_issue_c || (push_c && (occ_r == '0)))
                wait_r <= '0;
            else if ((occ_r != '0) && (wait_r != WAIT_W'(REPLAY_WAIT)))
                wait_r <= wait_r + WAIT_W'(1);
        end
    end

    // Replay queue storage
    always_ff @(posedge clk) begin
        if (push_c) rp_q[tail_r] <= '{id: s1_id_r, level: s1_level_r, tag: s1_tag_r,
                                      retry: s1_retry_r + RTY_W'(1)};
    end

    if (OUT_REG != 0) begin : g_out_reg
        // Registered response stage
        always_ff @(posedge clk) begin
            if (rst) begin
                o_lut_vld_r    <= 1'b0;
                o_lut_tag      <= '0;
                o_lut_key      <= '0;
                o_lut_size     <= '0;
                o_lut_listsize <= '0;
                o_lut_error    <= 1'b0;
                o_lut_err_code <= '0;
            end else begin
                o_lut_vld_r    <= resp_c;
                o_lut_tag      <= s1_tag_r;
                o_lut_key      <= key_c;
                o_lut_size     <= vol_c;
                o_lut_listsize <= i_state_rdata.listsize;
                o_lut_error    <= err_c;
                o_lut_err_code <= code_c;
            end
        end
    end else begin : g_out_comb
        // Response straight from S1
        always_comb begin
            o_lut_vld_r    = resp_c;
            o_lut_tag      = s1_tag_r;
            o_lut_key      = key_c;
            o_lut_size     = vol_c;
            o_lut_listsize = i_state_rdata.listsize;
            o_lut_error    = err_c;
            o_lut_err_code = code_c;
        end
    end
endmodule

// File: tb/tb_v_pipe_query_replay.sv
// Testbench for v_pipe_query_replay: table-driven queries plus replay corner cases.
module tb_v_pipe_query_replay;
    localparam int unsigned UPD_N = 4;

    typedef struct {
        v_pkg::id_t    id;
        v_pkg::level_t lvl;
        logic [7:0]    tag;
        logic [1:0]    code;
        logic [15:0]   key;
        logic [15:0]   vol;
        logic [2:0]    ls;
    } vec_t;

    typedef struct {
        logic [7:0]  tag;
        logic [1:0]  code;
        logic [2:0]  ls;
        logic [15:0] key;
        logic [15:0] vol;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic i_lut_vld;
    v_pkg::id_t i_lut_prod_id;
    v_pkg::level_t i_lut_level;
    logic [7:0] i_lut_tag;
    logic [UPD_N-1:0] upd_vld;
    v_pkg::id_t [UPD_N-1:0] upd_id;
    v_pkg::state_t rdata;

    logic ready0, vld0, err0, ren0, ready1, vld1, err1, ren1;
    logic [7:0] tag0, tag1;
    v_pkg::key_t key0, key1;
    v_pkg::volume_t size0, size1;
    v_pkg::listsize_t ls0, ls1;
    logic [1:0] code0, code1;
    v_pkg::addr_t raddr0, raddr1;

    v_pipe_query_replay #(.OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .i_lut_vld(i_lut_vld), .i_lut_prod_id(i_lut_prod_id),
        .i_lut_level(i_lut_level), .i_lut_tag(i_lut_tag), .o_lut_ready(ready0),
        .o_lut_vld_r(vld0), .o_lut_tag(tag0), .o_lut_key(key0), .o_lut_size(size0),
        .o_lut_listsize(ls0), .o_lut_error(err0), .o_lut_err_code(code0),
        .o_state_ren(ren0), .o_state_raddr(raddr0), .i_state_rdata(rdata),
        .i_upd_vld_r(upd_vld), .i_upd_prod_id_r(upd_id));

    v_pipe_query_replay #(.OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .i_lut_vld(i_lut_vld), .i_lut_prod_id(i_lut_prod_id),
        .i_lut_level(i_lut_level), .i_lut_tag(i_lut_tag), .o_lut_ready(ready1),
        .o_lut_vld_r(vld1), .o_lut_tag(tag1), .o_lut_key(key1), .o_lut_size(size1),
        .o_lut_listsize(ls1), .o_lut_error(err1), .o_lut_err_code(code1),
        .o_state_ren(ren1), .o_state_raddr(raddr1), .i_state_rdata(rdata),
        .i_upd_vld_r(upd_vld), .i_upd_prod_id_r(upd_id));

    v_pkg::state_t mem [256];
    exp_t sb [$];
    vec_t vecs [8];
    int iss [8];
    int resp_cyc [256];
    int resp1_cyc [256];
    logic [15:0] resp1_key [256];
    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    int n_resp = 0;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // state table read port model: data valid the cycle after the enable
    always @(posedge clk) if (ren0) rdata <= mem[raddr0];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input v_pkg::id_t id, input v_pkg::level_t lvl, input logic [7:0] tag);
        i_lut_vld = 1'b1;
        i_lut_prod_id = id;
        i_lut_level = lvl;
        i_lut_tag = tag;
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    function automatic v_pkg::state_t mk(input v_pkg::id_t id, input logic [3:0] v, input logic [2:0] ls);
        v_pkg::state_t s;
        s.vld = v;
        s.listsize = ls;
        for (int l = 0; l < 4; l++) begin
            s.key[l] = {id, 8'hA0 + 8'(l)};
            s.volume[l] = 16'(int'(id) * 100 + l);
        end
        return s;
    endfunction

    function automatic exp_t exp_of(input v_pkg::id_t id, input v_pkg::level_t lvl,
                                    input logic [7:0] tag, input logic exhausted);
        exp_t e;
        e.tag = tag;
        e.ls = mem[id].listsize;
        e.code = exhausted ? 2'd2 : (mem[id].vld[lvl] ? 2'd0 : 2'd1);
        e.key = (e.code == 2'd0) ? mem[id].key[lvl] : 16'h0;
        e.vol = (e.code == 2'd0) ? mem[id].volume[lvl] : 16'h0;
        return e;
    endfunction

    // scoreboard: match each response by tag against pending expectations
    always @(negedge clk) begin
        int idx;
        logic [45:0] act, expv;
        if (vld0 === 1'b1) begin
            idx = -1;
            n_resp++;
            resp_cyc[tag0] = cyc;
            foreach (sb[i]) if (idx < 0 && sb[i].tag == tag0) idx = i;
            if (idx < 0) begin
                n_total++;
                $display("FAIL unexpected_resp: got tag %0h code %0d, expected no response (cycle %0d)",
                         tag0, code0, cyc);
            end else begin
                expv = {sb[idx].tag, sb[idx].code, sb[idx].code != 2'd0, sb[idx].ls,
                        sb[idx].key, sb[idx].vol};
                act  = {tag0, code0, err0, ls0,
                        (sb[idx].code == 2'd0) ? key0 : 16'h0,
                        (sb[idx].code == 2'd0) ? size0 : 16'h0};
                chk($sformatf("resp_tag_%0h", tag0), 64'(act), 64'(expv));
                sb.delete(idx);
            end
        end
        if (vld1 === 1'b1) begin
            resp1_cyc[tag1] = cyc;
            resp1_key[tag1] = key1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, acc, cnt, n0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = mk(8'(i), 4'b0000, 3'd0);
            resp_cyc[i] = -1;
            resp1_cyc[i] = -1;
            resp1_key[i] = '0;
        end
        mem[5]     = mk(8'd5, 4'b0111, 3'd3);
        mem[7]     = mk(8'd7, 4'b1111, 3'd4);
        mem[9]     = mk(8'd9, 4'b0001, 3'd1);
        mem[8'h2A] = mk(8'h2A, 4'b0100, 3'd1);

        vecs[0] = '{8'd5,    2'd2, 8'h11, 2'd0, 16'h05A2, 16'd502,  3'd3};
        vecs[1] = '{8'd5,    2'd3, 8'h12, 2'd1, 16'h0,    16'h0,    3'd3};
        vecs[2] = '{8'd7,    2'd0, 8'h13, 2'd0, 16'h07A0, 16'd700,  3'd4};
        vecs[3] = '{8'd7,    2'd3, 8'h14, 2'd0, 16'h07A3, 16'd703,  3'd4};
        vecs[4] = '{8'd9,    2'd0, 8'h15, 2'd0, 16'h09A0, 16'd900,  3'd1};
        vecs[5] = '{8'd9,    2'd1, 8'h16, 2'd1, 16'h0,    16'h0,    3'd1};
        vecs[6] = '{8'h20,   2'd0, 8'h17, 2'd1, 16'h0,    16'h0,    3'd0};
        vecs[7] = '{8'h2A,   2'd2, 8'h18, 2'd0, 16'h2AA2, 16'd4202, 3'd1};

        rst = 1'b1;
        i_lut_vld = 1'b0;
        i_lut_prod_id = '0;
        i_lut_level = '0;
        i_lut_tag = '0;
        upd_vld = '0;
        upd_id = '0;
        tick();
        tick();
        rst = 1'b0;

        // first cycle after reset
        @(negedge clk);
        chk("rst_ready", 64'(ready0), 64'd1);
        chk("rst_vld", 64'(vld0), 64'd0);
        chk("rst_ren", 64'(ren0), 64'd0);
        chk("rst_outreg_zero", 64'({vld1, tag1, key1, size1, ls1, err1, code1}), 64'd0);
        tick();

        // back-to-back table queries, no collisions
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].id, vecs[i].lvl, vecs[i].tag);
            @(negedge clk);
            chk("tbl_ready", 64'(ready0), 64'd1);
            iss[i] = cyc;
            if (ready0) sb.push_back('{vecs[i].tag, vecs[i].code, vecs[i].ls, vecs[i].key, vecs[i].vol});
            tick();
        end
        i_lut_vld = 1'b0;
        wait_drain(20);
        for (int i = 0; i < 8; i++)
            chk($sformatf("tbl_latency_%0h", vecs[i].tag), 64'(resp_cyc[vecs[i].tag] - iss[i]), 64'd1);
        chk("outreg_latency", 64'(resp1_cyc[8'h11] - iss[0]), 64'd2);
        chk("outreg_key", 64'(resp1_key[8'h11]), 64'h05A2);

        // single collision with an update moving through stages 3 and 4
        upd_vld = 4'b0100;
        upd_id[2] = 8'd7;
        drive(8'd7, 2'd1, 8'h30);
        @(negedge clk);
        a = cyc;
        chk("replay1_ready", 64'(ready0), 64'd1);
        if (ready0) sb.push_back(exp_of(8'd7, 2'd1, 8'h30, 1'b0));
        tick();
        i_lut_vld = 1'b0;
        upd_vld = 4'b1000;
        upd_id[3] = 8'd7;
        upd_id[2] = '0;
        @(negedge clk);
        chk("replay1_no_resp", 64'(vld0), 64'd0);
        tick();
        upd_vld = '0;
        while (cyc < a + 6) tick();
        @(negedge clk);
        chk("replay1_ren", 64'(ren0), 64'd1);
        chk("replay1_raddr", 64'(raddr0), 64'd7);
        chk("replay1_ready_low", 64'(ready0), 64'd0);
        wait_drain(20);
        chk("replay1_latency", 64'(resp_cyc[8'h30] - a), 64'd7);

        // continuous collision: initial attempt plus three retries, then busy error
        tick();
        upd_vld = 4'b0001;
        upd_id = '0;
        upd_id[0] = 8'd7;
        drive(8'd7, 2'd0, 8'h31);
        @(negedge clk);
        a = cyc;
        if (ready0) sb.push_back(exp_of(8'd7, 2'd0, 8'h31, 1'b1));
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (ren0 === 1'b1 && raddr0 == 8'd7) cnt++;
            tick();
            i_lut_vld = 1'b0;
            @(negedge clk);
        end
        chk("exhaust_attempts", 64'(cnt), 64'd4);
        chk("exhaust_latency", 64'(resp_cyc[8'h31] - a), 64'd19);
        tick();
        upd_vld = '0;
        wait_drain(10);

        // queue full: input held off until a pop, stalled on the reissue cycle
        tick();
        upd_vld = 4'b0011;
        upd_id = '0;
        upd_id[0] = 8'd7;
        upd_id[1] = 8'd9;
        drive(8'd7, 2'd0, 8'h40);
        @(negedge clk);
        a = cyc;
        chk("full_ready_a0", 64'(ready0), 64'd1);
        if (ready0) sb.push_back(exp_of(8'd7, 2'd0, 8'h40, 1'b0));
        tick();
        drive(8'd9, 2'd0, 8'h41);
        @(negedge clk);
        chk("full_ready_a1", 64'(ready0), 64'd1);
        if (ready0) sb.push_back(exp_of(8'd9, 2'd0, 8'h41, 1'b0));
        tick();
        drive(8'd5, 2'd2, 8'h42);
        for (int k = 2; k <= 6; k++) begin
            if (k == 6) upd_vld = '0;
            @(negedge clk);
            chk($sformatf("full_ready_low_a%0d", k), 64'(ready0), 64'd0);
            if (k == 6) begin
                chk("full_replay_ren", 64'(ren0), 64'd1);
                chk("full_replay_raddr", 64'(raddr0), 64'd7);
            end
            tick();
        end
        acc = -1;
        for (int k = 0; k < 20 && acc < 0; k++) begin
            @(negedge clk);
            if (ready0 === 1'b1) begin
                acc = cyc;
                sb.push_back(exp_of(8'd5, 2'd2, 8'h42, 1'b0));
            end
            tick();
        end
        i_lut_vld = 1'b0;
        chk("full_stall_accept", 64'(acc - a), 64'd8);
        wait_drain(30);

        // reset with one query parked and one in S1: everything dropped
        tick();
        upd_vld = 4'b0011;
        drive(8'd7, 2'd0, 8'h50);
        @(negedge clk);
        tick();
        drive(8'd9, 2'd0, 8'h51);
        @(negedge clk);
        tick();
        i_lut_vld = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        upd_vld = '0;
        @(negedge clk);
        chk("midrst_ready", 64'(ready0), 64'd1);
        chk("midrst_vld", 64'(vld0), 64'd0);
        n0 = n_resp;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            if (ren0 === 1'b1) cnt++;
            tick();
            @(negedge clk);
        end
        chk("midrst_no_resp", 64'(n_resp - n0), 64'd0);
        chk("midrst_no_replay", 64'(cnt), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
